// File: rtl/hilo_div_sequencer.sv
// Multi-cycle restoring divider that sequences HI/LO writes for DIV/DIVU.
// Optional HILO_DIV_EARLY_EN: one-cycle finish when |dividend| < |divisor|.
module hilo_div_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  div_start,
  input  logic                  div_signed,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  stall_req,
  output logic                  busy,
  output logic                  hilo_write_en,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic q_neg;
    logic r_neg;
  } sign_t;

  state_t                state, state_nxt;
  sign_t                 sgn_q;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] rem_q, quo_q, dvs_q, hi_q, lo_q;
  logic [DATA_WIDTH-1:0] mag_dvd, mag_dvs;
  logic [DATA_WIDTH:0]   shifted, diff;
  logic [DATA_WIDTH-1:0] rem_nxt, quo_nxt, fin_hi, fin_lo;
  logic                  ld_op, ld_zero, ld_early, ld_fin;

  assign mag_dvd = (div_signed && dividend[DATA_WIDTH-1]) ? -dividend : dividend;
  assign mag_dvs = (div_signed && divisor[DATA_WIDTH-1])  ? -divisor  : divisor;

  // quo_q doubles as the dividend shift register: dividend bits leave at the
  // top while quotient bits enter at the bottom.
  assign shifted = {rem_q, quo_q[DATA_WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign rem_nxt = diff[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
  assign quo_nxt = {quo_q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
  assign fin_lo  = sgn_q.q_neg ? -quo_nxt : quo_nxt;
  assign fin_hi  = sgn_q.r_neg ? -rem_nxt : rem_nxt;

  assign busy          = (state != IDLE);
  assign hilo_write_en = (state == DONE);
  assign stall_req     = ~rst & div_start & ~flush & (state != DONE);
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_op     = 1'b0;
    ld_zero   = 1'b0;
    ld_early  = 1'b0;
    ld_fin    = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && div_start) begin
          if (divisor == '0) begin
            state_nxt = DONE;
            ld_zero   = 1'b1;
          end
`ifdef HILO_DIV_EARLY_EN
          else if (mag_dvd < mag_dvs) begin
            state_nxt = DONE;
            ld_early  = 1'b1;
          end
`endif
          else begin
            state_nxt = RUN;
            ld_op     = 1'b1;
          end
        end
      end
      RUN: begin
        // EX dropping the request mid-run is a cancel, same as a flush
        if (flush || !div_start) begin
          state_nxt = IDLE;
        end else if (cnt == LAST) begin
          state_nxt = DONE;
          ld_fin    = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      sgn_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      if (ld_op) begin
        cnt         <= '0;
        rem_q       <= '0;
        quo_q       <= mag_dvd;
        dvs_q       <= mag_dvs;
        sgn_q.q_neg <= div_signed & (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
        sgn_q.r_neg <= div_signed & dividend[DATA_WIDTH-1];
      end else if (state == RUN) begin
        cnt   <= cnt + CNT_WIDTH'(1);
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
      end
      // result registers only move on a completing transition
      if (ld_fin) begin
        hi_q <= fin_hi;
        lo_q <= fin_lo;
      end else if (ld_zero) begin
        hi_q <= dividend;
        lo_q <= '1;
      end else if (ld_early) begin
        hi_q <= dividend;
        lo_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_hilo_div_sequencer.sv
// Directed bench for hilo_div_sequencer: vector table plus flush/reset/back-to-back sequences.
module tb_hilo_div_sequencer;
  logic        clk, rst, flush, div_start, div_signed;
  logic [31:0] dividend, divisor;
  logic        stall_req, busy, hilo_write_en;
  logic [31:0] hi_o, lo_o;

  int checks   = 0;
  int failures = 0;
  logic [31:0] mhi, mlo;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        keep;
  } vec_t;

  vec_t vecs[11];

  hilo_div_sequencer #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .flush(flush), .div_start(div_start),
    .div_signed(div_signed), .dividend(dividend), .divisor(divisor),
    .stall_req(stall_req), .busy(busy), .hilo_write_en(hilo_write_en),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input vec_t v);
    if (v.b == 32'd0) return 1;
`ifdef HILO_DIV_EARLY_EN
    begin
      logic [31:0] ma, mb;
      ma = (v.sgn && v.a[31]) ? -v.a : v.a;
      mb = (v.sgn && v.b[31]) ? -v.b : v.b;
      if (ma < mb) return 1;
    end
`endif
    return 33;
  endfunction

  // Entered at an IDLE cycle; that cycle is cycle 0 of the divide.
  task automatic run_div(input vec_t v, input string tag);
    int lat, pulse, bad;
    lat = exp_lat(v);
    div_signed = v.sgn; dividend = v.a; divisor = v.b; div_start = 1'b1;
    #1;
    chk({tag, " stall_c0"}, {31'd0, stall_req}, 32'd1);
    chk({tag, " hi_before"}, hi_o, mhi);
    chk({tag, " lo_before"}, lo_o, mlo);
    pulse = -1; bad = 0;
    for (int c = 1; c <= 40 && pulse < 0; c++) begin
      @(posedge clk); #1;
      if (hilo_write_en) pulse = c;
      else begin
        if (!stall_req || !busy) bad++;
        if (hi_o !== mhi || lo_o !== mlo) bad++;
      end
    end
    chk({tag, " pulse_cycle"}, pulse, lat);
    chk({tag, " run_bad_cycles"}, bad, 0);
    chk({tag, " stall_done"}, {31'd0, stall_req}, 32'd0);
    chk({tag, " lo"}, lo_o, v.lo);
    chk({tag, " hi"}, hi_o, v.hi);
    mhi = v.hi; mlo = v.lo;
    if (!v.keep) div_start = 1'b0;
    @(posedge clk); #1;
    chk({tag, " busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, " wen_after"}, {31'd0, hilo_write_en}, 32'd0);
    chk({tag, " hi_hold"}, hi_o, mhi);
    if (v.keep) chk({tag, " stall_b2b"}, {31'd0, stall_req}, 32'd1);
  endtask

  initial begin
    int bad;
    vec_t v;
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b1};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
    vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b1};
    vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[5]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b0};
    vecs[6]  = '{1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   1'b0};
    vecs[7]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
    vecs[8]  = '{1'b1, 32'hFFFFFFFD,   32'd10,         32'd0,          32'hFFFFFFFD,   1'b0};
    vecs[9]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0};
    vecs[10] = '{1'b1, 32'd1000,       32'hFFFFFFF6,   32'hFFFFFF9C,   32'd0,          1'b0};

    rst = 1'b1; flush = 1'b0; div_start = 1'b0; div_signed = 1'b0;
    dividend = '0; divisor = '0;
    mhi = '0; mlo = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst wen", {31'd0, hilo_write_en}, 32'd0);
    chk("rst hi", hi_o, 32'd0);
    chk("rst lo", lo_o, 32'd0);
    div_start = 1'b1; #1;
    chk("rst stall_forced", {31'd0, stall_req}, 32'd0);
    div_start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_div(vecs[i], $sformatf("vec%0d", i));

    // flush at cycle 10 of a 100/7 run, then 9/3 from cycle 12
    div_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; div_start = 1'b1;
    bad = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (hilo_write_en || !busy) bad++;
    end
    chk("flush run_bad", bad, 0);
    flush = 1'b1; #1;
    chk("flush stall", {31'd0, stall_req}, 32'd0);
    @(posedge clk); #1;
    chk("flush busy", {31'd0, busy}, 32'd0);
    chk("flush wen", {31'd0, hilo_write_en}, 32'd0);
    chk("flush hi", hi_o, mhi);
    chk("flush lo", lo_o, mlo);
    flush = 1'b0; div_start = 1'b0;
    @(posedge clk); #1;
    v = '{1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0};
    run_div(v, "after_flush");

    // synchronous reset mid-run wipes the result registers
    div_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; div_start = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1; #1;
    chk("midrst stall", {31'd0, stall_req}, 32'd0);
    @(posedge clk); #1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst wen", {31'd0, hilo_write_en}, 32'd0);
    chk("midrst hi", hi_o, 32'd0);
    chk("midrst lo", lo_o, 32'd0);
    rst = 1'b0; div_start = 1'b0;
    mhi = '0; mlo = '0;
    @(posedge clk); #1;
    v = '{1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b0};
    run_div(v, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
